pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It combines EX-stage branch/jump resolution, ID-stage load-use detection and MEM-stage data-memory wait into one consistent set of per-stage write enables, bubble/flush strobes and PC-redirect controls. It tracks memory-wait duration with a timeout fault and keeps saturating performance counters. It sits beside the pipeline registers and drives every one of their enable and flush inputs.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer: next-PC ops, PC source select, FSM states.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'b00,
    NPC_BR   = 2'b01,
    NPC_JAL  = 2'b10,
    NPC_JALR = 2'b11
  } npc_op_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_TGT   = 2'b01,
    PC_JALR  = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FAULT    = 2'b10
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard sources: EX-stage taken branch/jump and ID-stage load-use dependency.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [1:0]        npc_op,
  input  logic              alu_f,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              lduse,
  output logic              taken
);

  assign taken = ((npc_op == NPC_BR) & alu_f) | (npc_op == NPC_JAL) | (npc_op == NPC_JALR);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign lduse = ex_mem_read & (ex_rd != '0) &
                 ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: merges memory wait, taken branches and load-use into pipeline
// register enables, bubble strobes and PC redirect, with wait timeout and perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        npc_op,
  input  logic              alu_f,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              exmem_we,
  output logic              memwb_we,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              redirect,
  output logic [1:0]        pc_src,
  output logic              timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q;
  logic             lduse, taken, mem_stall;

  assign mem_stall = dmem_req & ~dmem_ready;

  pipe_hazard_ctrl_hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .npc_op      (npc_op),
    .alu_f       (alu_f),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .lduse       (lduse),
    .taken       (taken)
  );

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_we    = 1'b1;
    exmem_we   = 1'b1;
    memwb_we   = 1'b1;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    redirect   = 1'b0;
    pc_src     = PC_PLUS4;
    if ((state_q == ST_FAULT) || mem_stall) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (taken) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      redirect   = 1'b1;
      pc_src     = (npc_op == NPC_JALR) ? PC_JALR : PC_TGT;
    end else if (lduse) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      flush_idex = 1'b1;
    end
  end

  // wait_cnt counts consecutive stalled cycles, including the one that entered MEM_WAIT
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_stall) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_W'(WAIT_TIMEOUT)) begin
          state_d = ST_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_FAULT: ;
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_q | (state_d == ST_FAULT);
      if ((state_q != ST_FAULT) && !pc_we && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a rule model.
module tb_pipe_hazard_ctrl;

  localparam int WT = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic       rst_n;
    logic [1:0] npc_op;
    logic       alu_f;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       req;
    logic       rdy;
  } stim_t;

  typedef struct packed {
    logic [4:0]    we;        // pc, ifid, idex, exmem, memwb
    logic          fl_ifid;
    logic          fl_idex;
    logic          redir;
    logic [1:0]    src;
    logic          tmo;
    logic [CW-1:0] scnt;
    logic [CW-1:0] fcnt;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] npc_op;
  logic alu_f, id_rs1_used, id_rs2_used, ex_mem_read, dmem_req, dmem_ready;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we, flush_ifid, flush_idex, redirect, timeout;
  logic [1:0] pc_src;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .WAIT_TIMEOUT(WT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .npc_op(npc_op), .alu_f(alu_f),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .redirect(redirect), .pc_src(pc_src),
    .timeout(timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // reference model: consecutive stalled cycles, sticky fault, saturating counts
  int    m_run, m_stall, m_flush;
  bit    m_fault;
  resp_t exp_q[$];
  string name_q[$];
  int    tests = 0, fails = 0;

  function automatic resp_t predict(input stim_t s);
    resp_t r;
    bit stall, tk, ld;
    stall = s.req && !s.rdy;
    tk = (s.npc_op == 2'd1 && s.alu_f) || s.npc_op >= 2'd2;
    ld = s.mr && s.rd != 0 && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    r = '0;
    r.we = 5'b11111;
    if (m_fault || stall) r.we = 5'b00000;
    else if (tk) begin
      r.fl_ifid = 1; r.fl_idex = 1; r.redir = 1;
      r.src = (s.npc_op == 2'd3) ? 2'd2 : 2'd1;
    end else if (ld) begin
      r.we = 5'b00111; r.fl_idex = 1;
    end
    r.tmo  = m_fault;
    r.scnt = CW'(m_stall);
    r.fcnt = CW'(m_flush);
    return r;
  endfunction

  task automatic cyc(input stim_t s, input string nm);
    resp_t e;
    bit stall;
    @(posedge clk);
    #1;
    rst_n = s.rst_n; npc_op = s.npc_op; alu_f = s.alu_f; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_rs1_used = s.u1; id_rs2_used = s.u2; ex_rd = s.rd; ex_mem_read = s.mr;
    dmem_req = s.req; dmem_ready = s.rdy;
    if (!s.rst_n) begin
      m_run = 0; m_stall = 0; m_flush = 0; m_fault = 0;
    end
    e = predict(s);
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (s.rst_n && !m_fault) begin
      stall = s.req && !s.rdy;
      if (!e.we[4] && m_stall < (1 << CW) - 1) m_stall++;
      if (e.redir && m_flush < (1 << CW) - 1) m_flush++;
      if (!stall) m_run = 0;
      else if (m_run == WT) m_fault = 1;
      else m_run++;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      resp_t e, r;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      r = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, flush_ifid, flush_idex, redirect,
           pc_src, timeout, stall_cnt, flush_cnt};
      tests++;
      if (r !== e) begin
        fails++;
        $display("FAIL %s: got we=%b fl=%b%b rd=%b src=%0d tmo=%b sc=%0d fc=%0d, expected we=%b fl=%b%b rd=%b src=%0d tmo=%b sc=%0d fc=%0d",
                 nm, r.we, r.fl_ifid, r.fl_idex, r.redir, r.src, r.tmo, r.scnt, r.fcnt,
                 e.we, e.fl_ifid, e.fl_idex, e.redir, e.src, e.tmo, e.scnt, e.fcnt);
      end
    end
  end

  stim_t idle, s;

  initial begin
    idle = '0;
    idle.rst_n = 1'b1;
    rst_n = 1'b0; npc_op = 0; alu_f = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0;
    id_rs2_used = 0; ex_rd = 0; ex_mem_read = 0; dmem_req = 0; dmem_ready = 0;
    m_run = 0; m_stall = 0; m_flush = 0; m_fault = 0;

    s = idle; s.rst_n = 0;
    cyc(s, "reset"); cyc(s, "reset");
    cyc(idle, "idle");

    // load-use: one bubble
    s = idle; s.mr = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1;
    cyc(s, "lduse");
    cyc(idle, "lduse_after");
    s.rd = 0; s.rs2 = 0;
    cyc(s, "lduse_x0");

    // branch overrides load-use; jalr; not-taken
    s = idle; s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1; s.npc_op = 2'd1; s.alu_f = 1;
    cyc(s, "br_over_lduse");
    s.npc_op = 2'd3; cyc(s, "jalr");
    s.npc_op = 2'd1; s.alu_f = 0; cyc(s, "br_not_taken");
    s = idle; s.npc_op = 2'd2; cyc(s, "jal");

    // 3-cycle wait then release with jal
    s = idle; s.req = 1; s.npc_op = 2'd2;
    for (int i = 0; i < 3; i++) cyc(s, "mem_wait");
    s.rdy = 1; cyc(s, "mem_release_jal");
    cyc(idle, "after_wait");

    // async reset mid-wait, applied between edges
    s = idle; s.req = 1;
    cyc(s, "wait_pre_rst"); cyc(s, "wait_pre_rst");
    s.rst_n = 0; cyc(s, "async_rst");
    cyc(idle, "post_rst");

    // timeout: six cycles of stall, then ready, then reset clears
    s = idle; s.req = 1;
    for (int i = 0; i < 6; i++) cyc(s, "timeout_wait");
    s.rdy = 1; s.npc_op = 2'd2; cyc(s, "fault_hold");
    cyc(idle, "fault_hold");
    s = idle; s.rst_n = 0; cyc(s, "fault_rst");
    cyc(idle, "post_fault_rst");

    // saturation of stall counter
    s = idle; s.mr = 1; s.rd = 7; s.rs1 = 7; s.u1 = 1;
    for (int i = 0; i < 20; i++) cyc(s, "stall_sat");
    cyc(idle, "stall_sat_hold");
    s = idle; s.npc_op = 2'd2;
    for (int i = 0; i < 18; i++) cyc(s, "flush_sat");
    cyc(idle, "flush_sat_hold");

    // random traffic with small register space and occasional long waits/resets
    for (int n = 0; n < 3000; n++) begin
      s = idle;
      s.rst_n  = ($urandom_range(0, 59) != 0);
      s.npc_op = 2'($urandom_range(0, 3));
      s.alu_f  = 1'($urandom_range(0, 1));
      s.rs1    = 5'($urandom_range(0, 3));
      s.rs2    = 5'($urandom_range(0, 3));
      s.u1     = 1'($urandom_range(0, 1));
      s.u2     = 1'($urandom_range(0, 1));
      s.rd     = 5'($urandom_range(0, 3));
      s.mr     = 1'($urandom_range(0, 1));
      s.req    = ($urandom_range(0, 2) != 0);
      s.rdy    = ($urandom_range(0, 3) == 0);
      cyc(s, "random");
    end

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
